motor_duty_ramp: RTL

- Sits directly upstream of the 11-bit PWM generator in each motor channel.
- Accepts a signed 12-bit speed command and slew-limits it toward the target once per PWM period.
- Splits the result into two unsigned 11-bit duty words: forward and reverse, one per PWM instance.
- Runs its own free-running 11-bit period counter, reset together with the PWM counter, so duty changes land exactly on PWM period boundaries.

---
 rtl/motor_duty_ramp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/motor_duty_ramp.sv
// Slew-limits a signed 12-bit speed command once per 2048-cycle PWM period and
// splits it into forward/reverse duty words. Optional reversal dead time: DUTY_RAMP_DEADTIME_EN.
module motor_duty_ramp #(
    parameter int RAMP_STEP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cmd,
    input  logic        cmd_vld,
    input  logic        brake,
    output logic [10:0] duty_fwd,
    output logic [10:0] duty_rev,
    output logic        at_target
);

    // Handshake: cmd_vld is a single-cycle qualifier with no ready; cmd is taken on
    // every edge where cmd_vld is high and brake is low. brake is a level, not a pulse.

`ifdef DUTY_RAMP_DEADTIME_EN
    typedef enum logic [1:0] {ZERO, FWD, REV, DEAD} state_t;
`else
    typedef enum logic [1:0] {ZERO, FWD, REV} state_t;
`endif

    localparam logic signed [12:0] STEP = 13'(RAMP_STEP);

    logic [10:0]        cnt_q;
    logic               strobe;
    logic signed [11:0] target_q;
    logic signed [11:0] target_n;
    logic signed [11:0] cur_q;
    logic signed [11:0] cur_n;
    state_t             state_q;
    state_t             state_n;
    logic signed [12:0] cur_ext;
    logic signed [12:0] diff;
    logic signed [12:0] diff_abs;
    logic signed [12:0] stepped;
    logic [10:0]        duty_fwd_n;
    logic [10:0]        duty_rev_n;
    logic               at_target_n;

    // Free-running period counter, aligned with the downstream PWM counter.
    assign strobe = &cnt_q;

    function automatic state_t sign_state(input logic [11:0] v);
        if (v == '0) begin
            return ZERO;
        end else if (v[11]) begin
            return REV;
        end else begin
            return FWD;
        end
    endfunction

    // Unclamped slew step toward the target in 13-bit signed arithmetic.
    always_comb begin
        cur_ext  = {cur_q[11], cur_q};
        diff     = {target_q[11], target_q} - cur_ext;
        diff_abs = diff[12] ? -diff : diff;
        if (diff_abs <= STEP) begin
            stepped = {target_q[11], target_q};
        end else if (diff[12]) begin
            stepped = cur_ext - STEP;
        end else begin
            stepped = cur_ext + STEP;
        end
    end

`ifdef DUTY_RAMP_DEADTIME_EN
    logic cur_pos;
    logic cur_neg;
    logic tgt_pos;
    logic tgt_neg;
    logic reversal;
    logic crosses;

    assign cur_pos  = !cur_q[11] && (cur_q != '0);
    assign cur_neg  = cur_q[11];
    assign tgt_pos  = !target_q[11] && (target_q != '0);
    assign tgt_neg  = target_q[11];
    assign reversal = (cur_pos && tgt_neg) || (cur_neg && tgt_pos);
    // A reversing step that reaches or passes zero stops at zero instead.
    assign crosses  = (stepped[12] != cur_q[11]) || (stepped == '0);
`endif

    always_comb begin
        target_n = target_q;
        cur_n    = cur_q;
        state_n  = state_q;
        if (brake) begin
            target_n = '0;
            cur_n    = '0;
            state_n  = ZERO;
        end else begin
            if (strobe) begin
`ifdef DUTY_RAMP_DEADTIME_EN
                if (state_q == DEAD) begin
                    cur_n   = '0;
                    state_n = ZERO;
                end else if (reversal && crosses) begin
                    cur_n   = '0;
                    state_n = DEAD;
                end else begin
                    cur_n   = 12'(stepped);
                    state_n = sign_state(12'(stepped));
                end
`else
                cur_n   = 12'(stepped);
                state_n = sign_state(12'(stepped));
`endif
            end
            // Strobe above uses the old target; a coincident command lands next period.
            if (cmd_vld) begin
                target_n = (cmd == 12'h800) ? 12'h801 : cmd;
            end
        end
    end

    always_comb begin
        duty_fwd_n = cur_n[11] ? 11'd0 : cur_n[10:0];
        duty_rev_n = cur_n[11] ? 11'(-cur_n) : 11'd0;
`ifdef DUTY_RAMP_DEADTIME_EN
        at_target_n = (cur_n == target_n) && (state_n != DEAD);
`else
        at_target_n = (cur_n == target_n);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            target_q  <= '0;
            cur_q     <= '0;
            state_q   <= ZERO;
            duty_fwd  <= '0;
            duty_rev  <= '0;
            at_target <= 1'b1;
        end else begin
            cnt_q     <= cnt_q + 11'd1;
            target_q  <= target_n;
            cur_q     <= cur_n;
            state_q   <= state_n;
            duty_fwd  <= duty_fwd_n;
            duty_rev  <= duty_rev_n;
            at_target <= at_target_n;
        end
    end

endmodule
